// File: rtl/jt053247_pkg.sv
// Shared types and constants for the 053247 sprite tile-row drawer.
// Holds the draw FSM state type plus zoom and runaway-cap constants.
package jt053247_pkg;

    typedef enum logic [1:0] {StIdle, StFetch0, StFetch1, StDraw} state_t;

    localparam logic [9:0]  ZOOM_UNIT = 10'h40;
    localparam int unsigned MAX_DPX   = 512;
    localparam int unsigned PXW       = 4;
    localparam logic [8:0]  DPX_LAST  = 9'(MAX_DPX - 1);

    // A zero zoom would never advance the accumulator; force the slowest step.
    function automatic logic [9:0] zoom_step(input logic [9:0] hzoom);
        return (hzoom == '0) ? 10'd1 : hzoom;
    endfunction

endpackage

// File: rtl/jt053247_rowsel.sv
// Holds the 16-pixel tile row fetched as two ROM words and selects one pixel
// by source index, optionally mirrored.
module jt053247_rowsel
    import jt053247_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    input  logic           load_lo,
    input  logic           load_hi,
    input  logic [31:0]    data,
    input  logic [3:0]     src,
    input  logic           hflip,
    output logic [PXW-1:0] pix
);

    logic [63:0] row;
    logic [3:0]  idx;
    logic [5:0]  base;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row <= '0;
        end else begin
            if (load_lo) row[63:32] <= data;
            if (load_hi) row[31:0]  <= data;
        end
    end

    assign idx  = hflip ? (4'd15 - src) : src;
    // Pixel 0 sits in the top nibble, so pixel i starts at bit 4*(15-i).
    assign base = {~idx, 2'b00};
    assign pix  = row[base +: PXW];

endmodule

// File: rtl/jt053247_draw.sv
// Tile-row drawer: fetches one 16-pixel row as two ROM words, then writes
// zoomed pixels into the line buffer, one destination column per clock.
module jt053247_draw
    import jt053247_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        dr_start,
    output logic        dr_busy,
    input  logic [15:0] code,
    input  logic [9:0]  attr,
    input  logic [1:0]  shd,
    input  logic        hflip,
    input  logic [8:0]  hpos,
    input  logic [3:0]  ysub,
    input  logic [9:0]  hzoom,
    input  logic        hz_keep,
    output logic [20:0] rom_addr,
    output logic        rom_cs,
    input  logic        rom_ok,
    input  logic [31:0] rom_data,
    output logic        buf_we,
    output logic [8:0]  buf_addr,
    output logic [15:0] buf_data
);

    state_t         state;
    logic [10:0]    acc;
    logic [10:0]    acc_nxt;
    logic [9:0]     step;
    logic [9:0]     attr_l;
    logic [1:0]     shd_l;
    logic           hflip_l;
    logic [8:0]     xcur;
    logic [8:0]     dpx_cnt;
    logic           load_lo;
    logic           load_hi;
    logic [PXW-1:0] pix;

    assign acc_nxt = acc + {1'b0, step};
    assign load_lo = (state == StFetch0) && rom_ok;
    assign load_hi = (state == StFetch1) && rom_ok;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= StIdle;
            dr_busy  <= 1'b0;
            rom_cs   <= 1'b0;
            rom_addr <= '0;
            acc      <= '0;
            xcur     <= '0;
            dpx_cnt  <= '0;
            step     <= '0;
            attr_l   <= '0;
            shd_l    <= '0;
            hflip_l  <= 1'b0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (dr_start) begin
                        state    <= StFetch0;
                        dr_busy  <= 1'b1;
                        rom_cs   <= 1'b1;
                        rom_addr <= {code, ysub, 1'b0};
                        step     <= zoom_step(hzoom);
                        attr_l   <= attr;
                        shd_l    <= shd;
                        hflip_l  <= hflip;
                        dpx_cnt  <= '0;
                        // Chained tiles keep the column and only the sub-pixel fraction.
                        if (hz_keep) begin
                            acc <= {1'b0, acc[9:0]};
                        end else begin
                            acc  <= '0;
                            xcur <= hpos;
                        end
                    end
                end
                StFetch0: begin
                    if (rom_ok) begin
                        state       <= StFetch1;
                        rom_addr[0] <= 1'b1;
                    end
                end
                StFetch1: begin
                    if (rom_ok) begin
                        state  <= StDraw;
                        rom_cs <= 1'b0;
                    end
                end
                StDraw: begin
                    xcur    <= xcur + 9'd1;
                    acc     <= acc_nxt;
                    dpx_cnt <= dpx_cnt + 9'd1;
                    if (acc_nxt[10] || (dpx_cnt == DPX_LAST)) begin
                        state   <= StIdle;
                        dr_busy <= 1'b0;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

    jt053247_rowsel u_rowsel (
        .clk     (clk),
        .rst     (rst),
        .load_lo (load_lo),
        .load_hi (load_hi),
        .data    (rom_data),
        .src     (acc[9:6]),
        .hflip   (hflip_l),
        .pix     (pix)
    );

    assign buf_we   = (state == StDraw) && (pix != '0);
    assign buf_addr = xcur;
    assign buf_data = {shd_l, attr_l, pix};

endmodule

// File: doc/jt053247_draw.md
JT053247_DRAW -- requirements
Module: jt053247_draw

Interface
REQ-001 clk  input  1  system clock; all state updates on rising edge.
REQ-002 rst  input  1  reset, asynchronous, active-high.
REQ-003 dr_start  input  1  draw request from sprite scanner; may stay high up to 2 clk.
REQ-004 dr_busy  output  1  high while a tile row is being fetched or drawn.
REQ-005 code  input  16  tile code, sampled on accept.
REQ-006 attr  input  10  palette/priority attribute, sampled on accept.
REQ-007 shd  input  2  shadow bits, sampled on accept.
REQ-008 hflip  input  1  horizontal flip, sampled on accept.
REQ-009 hpos  input  9  destination start column, sampled on accept.
REQ-010 ysub  input  4  tile row 0-15, sampled on accept.
REQ-011 hzoom  input  10  source step per destination pixel in 1/64 px units; 0x40 = 1:1.
REQ-012 hz_keep  input  1  continue position and fraction from previous tile.
REQ-013 rom_addr  output  21  32-bit word address {code, ysub, half}.
REQ-014 rom_cs  output  1  ROM request, held until rom_ok.
REQ-015 rom_ok  input  1  rom_data valid for the current rom_addr.
REQ-016 rom_data  input  32  8 pixels, 4 bpp; pixel 0 in bits [31:28].
REQ-017 buf_we  output  1  line-buffer write strobe.
REQ-018 buf_addr  output  9  line-buffer column.
REQ-019 buf_data  output  16  {shd, attr, pixel[3:0]}.

Function
REQ-020 States: IDLE, FETCH0, FETCH1, DRAW; IDLE -> FETCH0 when dr_start=1 in IDLE; all inputs latched that cycle.
REQ-021 dr_start SHALL be ignored in any state other than IDLE.
REQ-022 dr_busy SHALL be 1 in FETCH0/FETCH1/DRAW, 0 in IDLE; it rises the clk after accept.
REQ-023 FETCH0: rom_cs=1, rom_addr={code,ysub,1'b0}; on rom_ok, latch the word as pixels 0-7 and go to FETCH1.
REQ-024 FETCH1: same with half=1 for pixels 8-15; on rom_ok go to DRAW; rom_cs drops the cycle after each rom_ok.
REQ-025 A rom_ok arriving in the same cycle rom_cs first rises SHALL be accepted (zero-wait ROM).
REQ-026 Accumulator acc is 11 bits; source index src=acc[9:6], mirrored to 15-src when hflip=1.
REQ-027 DRAW: one destination pixel per clk: buf_addr=xcur, buf_data={shd,attr,pix[src]}, buf_we=1 only if pix!=0; then xcur+=1 (9-bit wrap), acc+=step.
REQ-028 step = hzoom, except hzoom=0 gives step=1.
REQ-029 DRAW ends, returning to IDLE, when acc[10]=1 after the add, or after 512 destination pixels (runaway cap).
REQ-030 On accept with hz_keep=0: acc=0, xcur=hpos; with hz_keep=1: acc={1'b0,acc[9:0]} (residual fraction), xcur continues from its last value; hpos is ignored.
REQ-031 At 1:1 (hzoom=0x40) a tile SHALL produce exactly 16 DRAW cycles; total busy = 16 + ROM wait cycles + 2.
REQ-032 Column wrap 511 -> 0 SHALL be allowed silently; no clipping inside the block.
REQ-033 buf_we SHALL be 0 outside DRAW.

Reset
REQ-034 On rst: state=IDLE, dr_busy=0, rom_cs=0, rom_addr=0, buf_we=0, buf_addr=0, buf_data=0, acc=0, xcur=0, pixel latches=0.
REQ-035 rst asserted mid-fetch or mid-draw SHALL abort immediately; no write or ROM request follows.

Structure
REQ-036 Package jt053247_pkg holds the state enum, ZOOM_UNIT=10'h40, MAX_DPX=512 and the pixel-width constant.
REQ-037 One sub-module, jt053247_rowsel: 64-bit row register with 4-bit mux by src and hflip, combinational output.

Verification
REQ-038 Reset: hold rst mid-DRAW -> dr_busy=0, buf_we=0 the same cycle; no writes after release until the next dr_start.
REQ-039 1:1 tile: code=0x1234, ysub=5, hpos=0x20, hzoom=0x40, rom_data=0x12345678/0x9ABCDEF0, zero-wait ROM -> rom_addr 0x02468A then 0x02468B; columns 0x20-0x2E written with pixels 1..F in order; 0x2F not written (pixel 0); dr_busy high 18 clk.
REQ-040 hflip=1, same data -> column 0x20 gets pixel 0 (skipped), 0x21 gets F, ... 0x2F gets 1.
REQ-041 Enlarge: hzoom=0x20 -> 32 DRAW cycles, each source pixel written twice; shrink: hzoom=0x80 -> 8 cycles, even source pixels only.
REQ-042 hz_keep chain: hzoom=0x30 tile, then hz_keep=1 tile -> second tile starts at last column+1 with residual fraction; no gap or overlap; hpos ignored.
REQ-043 Handshake: dr_start held 2 clk, rom_ok delayed 5 clk per fetch -> a single tile drawn; rom_cs stable until rom_ok; dr_start during busy ignored; hzoom=0 -> stops at 512 pixels.
